// File: rtl/utils_pkg.sv
// Shared types for the iterative M-extension multiply/divide unit (mdu_iter).
package utils_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        RV_M_MUL    = 3'd0,
        RV_M_MULH   = 3'd1,
        RV_M_MULHSU = 3'd2,
        RV_M_MULHU  = 3'd3,
        RV_M_DIV    = 3'd4,
        RV_M_DIVU   = 3'd5,
        RV_M_REM    = 3'd6,
        RV_M_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_st_t;

    typedef struct packed {
        mdu_op_t               op;
        logic [MDU_XLEN-1:0]   rs1;
        logic [MDU_XLEN-1:0]   rs2;
        logic [4:0]            rd_addr;
    } s_mdu_req_t;

    function automatic logic rs1_is_signed(input mdu_op_t op);
        return op inside {RV_M_MUL, RV_M_MULH, RV_M_MULHSU, RV_M_DIV, RV_M_REM};
    endfunction

    function automatic logic rs2_is_signed(input mdu_op_t op);
        return op inside {RV_M_MUL, RV_M_MULH, RV_M_DIV, RV_M_REM};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: compare the shifted partial remainder against the divisor.
module mdu_div_step
    import utils_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    // When the subtraction succeeds the true difference is below the divisor, so XLEN bits suffice.
    assign q_o   = (rem_i >= {1'b0, div_i});
    assign rem_o = q_o ? (rem_i[XLEN-1:0] - div_i) : rem_i[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro MDU_FAST_MUL_EN: MUL* ops use a single-cycle product and skip CALC.
module mdu_iter
    import utils_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic [4:0]      res_rd_addr_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] mul_result(input mdu_op_t op, input logic neg,
                                                   input logic [2*XLEN-1:0] prod);
        logic [2*XLEN-1:0] p;
        p = neg ? (~prod + 1'b1) : prod;
        return (op == RV_M_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_result(input mdu_op_t op, input logic neg,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] rem);
        logic [XLEN-1:0] v;
        v = (op inside {RV_M_REM, RV_M_REMU}) ? rem : quo;
        return neg ? (~v + 1'b1) : v;
    endfunction

    mdu_st_t         state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    mdu_op_t         op_q, op_n, op_in;
    logic            neg_q, neg_n, neg_in;
    logic [XLEN-1:0] hi_q, hi_n, lo_q, lo_n, b_q, b_n, res_q, res_n;
    logic [XLEN:0]   rem_q, rem_n;
    logic [4:0]      rd_q, rd_n;
    logic            res_vld_q, busy_q;

    logic signed [XLEN-1:0] a_s, b_s;
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, step_rem;
    logic            step_q;
    logic [XLEN:0]   mul_sum;

    assign op_in    = mdu_op_t'(op_i);
    assign a_s      = signed'(rs1_i);
    assign b_s      = signed'(rs2_i);
    assign a_neg    = rs1_is_signed(op_in) && (a_s < 0);
    assign b_neg    = rs2_is_signed(op_in) && (b_s < 0);
    assign a_mag    = a_neg ? unsigned'(-a_s) : rs1_i;
    assign b_mag    = b_neg ? unsigned'(-b_s) : rs2_i;
    assign neg_in   = (op_in inside {RV_M_REM, RV_M_REMU}) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = op_i[2] && (rs2_i == '0);
    assign div_ovf  = (op_in inside {RV_M_DIV, RV_M_REM}) && (rs1_i == MIN_INT) && (rs2_i == '1);

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (rem_q),
        .div_i (b_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        neg_n   = neg_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        b_n     = b_q;
        rem_n   = rem_q;
        res_n   = res_q;
        rd_n    = rd_q;
        case (state)
            IDLE: begin
                if (op_valid_i && !flush_i) begin
                    op_n    = op_in;
                    rd_n    = rd_addr_i;
                    neg_n   = neg_in;
                    b_n     = b_mag;
                    hi_n    = '0;
                    cnt_n   = CW'(XLEN);
                    state_n = CALC;
                    // Divide keeps the dividend's MSB pre-loaded into the partial remainder.
                    if (op_i[2]) begin
                        rem_n = {{XLEN{1'b0}}, a_mag[XLEN-1]};
                        lo_n  = {a_mag[XLEN-2:0], 1'b0};
                    end else begin
                        rem_n = '0;
                        lo_n  = a_mag;
                    end
                    if (div_zero) begin
                        res_n   = op_i[1] ? rs1_i : '1;
                        state_n = DONE;
                    end else if (div_ovf) begin
                        res_n   = op_i[1] ? '0 : MIN_INT;
                        state_n = DONE;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!op_i[2]) begin
                        res_n   = mul_result(op_in, neg_in, fast_prod);
                        state_n = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                    if (op_q[2]) begin
                        rem_n = {step_rem, lo_q[XLEN-1]};
                        lo_n  = {lo_q[XLEN-2:0], step_q};
                    end else begin
                        hi_n  = mul_sum[XLEN:1];
                        lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt == CW'(1)) begin
                        state_n = DONE;
                        res_n   = op_q[2] ? div_result(op_q, neg_q, lo_n, step_rem)
                                          : mul_result(op_q, neg_q, {hi_n, lo_n});
                    end
                end
            end
            DONE: begin
                if (flush_i || res_ready_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            res_q     <= '0;
            rd_q      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            res_vld_q <= (state_n == DONE);
            busy_q    <= (state_n != IDLE);
            res_q     <= res_n;
            rd_q      <= rd_n;
        end
    end

    always_ff @(posedge clk) begin
        op_q  <= op_n;
        neg_q <= neg_n;
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        b_q   <= b_n;
        rem_q <= rem_n;
    end

    assign op_ready_o    = (state == IDLE);
    assign res_valid_o   = res_vld_q;
    assign busy_o        = busy_q;
    assign res_o         = res_q;
    assign res_rd_addr_o = rd_q;

endmodule
